// File: rtl/fib_requester_pkg.sv
// Shared types and constants for the fib request sequencer.
// Imported by the requester RTL and its bench.
package fib_requester_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_REL
  } state_t;

  localparam int N_IN_DEF  = 7;
  localparam int N_OUT_DEF = 64;

  localparam logic [63:0] FIB_0 = 64'd0;
  localparam logic [63:0] FIB_1 = 64'd1;

endpackage

// File: rtl/fib_requester_if.sv
// Responder req/ack link plus the (n, result) output stream.
// master = requester side, slave = responder/sink side.
interface fib_requester_if
  import fib_requester_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) ();

  logic             req;
  logic [N_IN-1:0]  n;
  logic             ack;
  logic [N_OUT-1:0] result;

  logic             out_valid;
  logic             out_ready;
  logic [N_IN-1:0]  out_n;
  logic [N_OUT-1:0] out_result;

  modport master (
    output req, n,
    input  ack, result,
    output out_valid, out_n, out_result,
    input  out_ready
  );

  modport slave (
    input  req, n,
    output ack, result,
    input  out_valid, out_n, out_result,
    output out_ready
  );

endinterface

// File: rtl/fib_req_fifo.sv
// Two-entry synchronous FIFO buffering captured (n, result) pairs.
// Push and pop may occur in the same cycle.
module fib_req_fifo #(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/fib_requester.sv
// Sweeps n over [n_first, n_last] using a four-phase req/ack link
// and streams each (n, fib(n)) pair out through a 2-deep FIFO.
module fib_requester
  import fib_requester_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N_IN-1:0] n_first,
  input  logic [N_IN-1:0] n_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  fib_requester_if.master bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int W  = N_IN + N_OUT;

  state_t          state;
  state_t          state_nx;
  logic [N_IN-1:0] cur;
  logic [N_IN-1:0] last;
  logic [N_IN-1:0] n_q;
  logic            req_q;
  logic [CW-1:0]   cnt;
  logic            tmo;

  logic go;
  logic nogo;
  logic issue;
  logic capture;
  logic advance;
  logic finish;
  logic abort;

  logic         full;
  logic         empty;
  logic         pop;
  logic [W-1:0] head;

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start && n_first <= n_last)
          state_nx = ISSUE;
      ISSUE:
        if (!full && !bus.ack)
          state_nx = WAIT_ACK;
      WAIT_ACK:
        if (bus.ack)  state_nx = WAIT_REL;
        else if (tmo) state_nx = IDLE;
      WAIT_REL:
        if (!bus.ack)
          state_nx = (cur == last) ? IDLE : ISSUE;
        else if (tmo)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    go      = 1'b0;
    nogo    = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        go   = start && (n_first <= n_last);
        nogo = start && (n_first > n_last);
      end
      ISSUE:
        issue = !full && !bus.ack;
      WAIT_ACK: begin
        capture = bus.ack;
        abort   = !bus.ack && tmo;
      end
      WAIT_REL: begin
        finish  = !bus.ack && (cur == last);
        advance = !bus.ack && (cur != last);
        abort   = bus.ack && tmo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      n_q   <= '0;
      cur   <= '0;
      last  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= nogo | finish | abort;
      if (go | nogo) err <= 1'b0;
      if (abort)     err <= 1'b1;
      if (go) begin
        cur  <= n_first;
        last <= n_last;
        busy <= 1'b1;
      end
      if (finish | abort) busy <= 1'b0;
      if (issue) begin
        req_q <= 1'b1;
        n_q   <= cur;
      end
      if (capture | abort) req_q <= 1'b0;
      if (advance) cur <= cur + 1'b1;
      // counter restarts on entry to either wait state
      if (issue | capture)
        cnt <= '0;
      else if ((state == WAIT_ACK || state == WAIT_REL) && !tmo)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.req = req_q;
  assign bus.n   = n_q;

  assign pop = !empty && bus.out_ready;

  fib_req_fifo #(
    .W(W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   ({cur, bus.result}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign {bus.out_n, bus.out_result} = head;

endmodule

// File: tb/tb_fib_requester.sv
// Directed bench: fib responder model, output scoreboard, timeouts.
module tb_fib_requester;
  import fib_requester_pkg::*;

  localparam int NI = 7;
  localparam int NO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NI-1:0] n_first;
  logic [NI-1:0] n_last;
  logic          busy;
  logic          done;
  logic          err;
  logic          mute;

  int total = 0;
  int bad   = 0;

  int done_cnt = 0;
  int req_hi   = 0;
  int rises    = 0;
  int viol     = 0;
  logic req_prev = 1'b0;
  logic ack_prev = 1'b0;

  logic [NI+NO-1:0] exp_q [$];
  logic [NI+NO-1:0] got_q [$];

  fib_requester_if #(.N_IN(NI), .N_OUT(NO)) bus ();

  fib_requester #(
    .N_IN(NI), .N_OUT(NO), .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n_first (n_first),
    .n_last  (n_last),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fib(input int k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = FIB_0;
    b = FIB_1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // registered four-phase responder; mute withholds ack
  always @(posedge clk) begin
    if (rst) begin
      bus.ack    <= 1'b0;
      bus.result <= '0;
    end else if (bus.req && !bus.ack && !mute) begin
      bus.ack    <= 1'b1;
      bus.result <= fib(int'(bus.n));
    end else if (!bus.req) begin
      bus.ack <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.req) req_hi++;
    if (bus.req && !req_prev) begin
      rises++;
      if (ack_prev) viol++;
    end
    req_prev = bus.req;
    ack_prev = bus.ack;
    if (!rst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_n, bus.out_result});
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int a, input int b);
    @(posedge clk); #1;
    start   = 1'b1;
    n_first = NI'(a);
    n_last  = NI'(b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_range(input int a, input int b);
    for (int k = a; k <= b; k++)
      exp_q.push_back({NI'(k), fib(k)});
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = done;
    end
    check(tag, 128'(hit), 128'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = bus.req;
    end
    check(tag, 128'(hit), 128'd1);
  endtask

  task automatic drain(input string tag);
    logic [NI+NO-1:0] g;
    logic [NI+NO-1:0] e;
    while (exp_q.size() > 0) begin
      if (got_q.size() == 0) begin
        check({tag, "_missing"}, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
      end else begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        check(tag, 128'(g), 128'(e));
      end
    end
    check({tag, "_extra"}, 128'(got_q.size()), 128'd0);
  endtask

  initial begin
    int d0;
    int r0;
    int h0;
    rst           = 1'b1;
    start         = 1'b0;
    n_first       = '0;
    n_last        = '0;
    mute          = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);

    check("rst_req",   128'(bus.req),       128'd0);
    check("rst_n",     128'(bus.n),         128'd0);
    check("rst_busy",  128'(busy),          128'd0);
    check("rst_done",  128'(done),          128'd0);
    check("rst_err",   128'(err),           128'd0);
    check("rst_valid", 128'(bus.out_valid), 128'd0);
    rst = 1'b0;
    tick(2);

    // sweep 0..10
    d0 = done_cnt;
    expect_range(0, 10);
    pulse_start(0, 10);
    wait_done("s010_done", 400);
    tick(6);
    drain("s010_pair");
    check("s010_done_cnt", 128'(done_cnt - d0), 128'd1);
    check("s010_err",      128'(err),           128'd0);
    check("s010_viol",     128'(viol),          128'd0);

    // single value, fixed reference constant
    exp_q.push_back({7'd66, 64'd27777890035288});
    pulse_start(66, 66);
    check("s66_busy_on", 128'(busy), 128'd1);
    wait_done("s66_done", 100);
    check("s66_busy_off", 128'(busy), 128'd0);
    tick(6);
    drain("s66_pair");

    // top of range must not wrap
    r0 = rises;
    d0 = done_cnt;
    expect_range(126, 127);
    pulse_start(126, 127);
    wait_done("s126_done", 100);
    tick(10);
    drain("s126_pair");
    check("s126_reqs", 128'(rises - r0),    128'd2);
    check("s126_done_cnt", 128'(done_cnt - d0), 128'd1);

    // backpressure
    bus.out_ready = 1'b0;
    expect_range(0, 5);
    pulse_start(0, 5);
    tick(40);
    check("bp_req",   128'(bus.req),       128'd0);
    check("bp_busy",  128'(busy),          128'd1);
    check("bp_valid", 128'(bus.out_valid), 128'd1);
    check("bp_got",   128'(got_q.size()),  128'd0);
    bus.out_ready = 1'b1;
    wait_done("bp_done", 400);
    tick(6);
    drain("bp_pair");

    // timeout
    mute = 1'b1;
    h0   = req_hi;
    pulse_start(20, 25);
    wait_done("to_done", 100);
    check("to_req_hi", 128'(req_hi - h0), 128'd16);
    check("to_err",    128'(err),         128'd1);
    check("to_req",    128'(bus.req),     128'd0);
    check("to_busy",   128'(busy),        128'd0);
    mute = 1'b0;
    tick(4);
    expect_range(7, 7);
    pulse_start(7, 7);
    check("to_err_clr", 128'(err), 128'd0);
    wait_done("to_next_done", 100);
    tick(6);
    drain("to_next_pair");

    // empty range
    r0 = rises;
    d0 = done_cnt;
    pulse_start(5, 3);
    check("neg_done", 128'(done), 128'd1);
    check("neg_busy", 128'(busy), 128'd0);
    tick(4);
    check("neg_reqs",  128'(rises - r0),    128'd0);
    check("neg_dcnt",  128'(done_cnt - d0), 128'd1);

    // reset while stuck in WAIT_ACK with data buffered
    bus.out_ready = 1'b0;
    pulse_start(0, 5);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
        @(negedge clk);
        hit = bus.out_valid;
      end
      check("mr_first_pair", 128'(hit), 128'd1);
    end
    mute = 1'b1;
    wait_req("mr_req", 50);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_req_off",   128'(bus.req),       128'd0);
    check("mr_busy_off",  128'(busy),          128'd0);
    check("mr_valid_off", 128'(bus.out_valid), 128'd0);
    rst           = 1'b0;
    mute          = 1'b0;
    bus.out_ready = 1'b1;
    tick(4);
    check("mr_got", 128'(got_q.size()), 128'd0);
    check("final_viol", 128'(viol), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
